// File: rtl/mod_count_sequencer.sv
// Modulo-N counter sequencer: steps one counter through a programmable table
// of {modulus, repetitions} phases, with a start/done handshake and abort.
module mod_count_sequencer #(
   parameter int W          = 8,
   parameter int NUM_PHASES = 4,
   parameter int PW         = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          cfg_we_i,
   input  logic [PW-1:0] cfg_idx_i,
   input  logic [W-1:0]  cfg_mod_i,
   input  logic [7:0]    cfg_reps_i,
   input  logic          start_i,
   input  logic          pause_i,
   input  logic          abort_i,
   output logic [W-1:0]  count_o,
   output logic [PW-1:0] phase_o,
   output logic          wrap_o,
   output logic          busy_o,
   output logic          done_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_PHASES - 1);
   localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
   localparam logic [W-1:0]  CNT_ONE    = W'(1);
   localparam logic [7:0]    REP_ONE    = 8'd1;

   // Phase table
   logic [W-1:0] tab_mod_q  [NUM_PHASES];
   logic [7:0]   tab_reps_q [NUM_PHASES];

   // Control and datapath state
   state_e        state_q,    state_d;
   logic [W-1:0]  count_q,    count_d;
   logic [W-1:0]  act_mod_q,  act_mod_d;
   logic [7:0]    act_reps_q, act_reps_d;
   logic [7:0]    rep_cnt_q,  rep_cnt_d;
   logic [PW-1:0] phase_q,    phase_d;
   logic          wrap_q,     wrap_d;
   logic          busy_q,     busy_d;
   logic          done_q,     done_d;

   logic [W-1:0]  entry_mod;
   logic [7:0]    entry_reps;
   logic          entry_en;
   logic          last_phase;
   logic          at_top;
   logic          last_rep;

   assign entry_mod  = tab_mod_q[phase_q];
   assign entry_reps = tab_reps_q[phase_q];
   assign entry_en   = (entry_mod != '0) && (entry_reps != '0);
   assign last_phase = (phase_q == LAST_PHASE);
   // Wrap decisions use only the latched values so table writes never disturb a running phase.
   assign at_top     = (count_q == act_mod_q - CNT_ONE);
   assign last_rep   = (rep_cnt_q == act_reps_q - REP_ONE);

   // NOTE: the table is cleared on reset on purpose; an all-zero table means
   // every phase is disabled, so its reset value is architecturally visible.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_PHASES; i++) begin
            tab_mod_q[i]  <= '0;
            tab_reps_q[i] <= '0;
         end
      end else if (cfg_we_i && (cfg_idx_i <= LAST_PHASE)) begin
         tab_mod_q[cfg_idx_i]  <= cfg_mod_i;
         tab_reps_q[cfg_idx_i] <= cfg_reps_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      if (abort_i) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start_i) state_d = S_LOAD;
            end
            S_LOAD: begin
               if (entry_en)        state_d = S_RUN;
               else if (last_phase) state_d = S_DONE;
            end
            S_RUN: begin
               if (!pause_i && at_top && last_rep) begin
                  state_d = last_phase ? S_DONE : S_LOAD;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      count_d    = count_q;
      phase_d    = phase_q;
      rep_cnt_d  = rep_cnt_q;
      act_mod_d  = act_mod_q;
      act_reps_d = act_reps_q;
      wrap_d     = 1'b0;

      if (abort_i) begin
         count_d   = '0;
         phase_d   = '0;
         rep_cnt_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  count_d   = '0;
                  phase_d   = '0;
                  rep_cnt_d = '0;
               end
            end
            S_LOAD: begin
               act_mod_d  = entry_mod;
               act_reps_d = entry_reps;
               count_d    = '0;
               rep_cnt_d  = '0;
               if (!entry_en && !last_phase) phase_d = phase_q + PHASE_ONE;
            end
            S_RUN: begin
               if (!pause_i) begin
                  if (at_top) begin
                     count_d   = '0;
                     wrap_d    = 1'b1;
                     rep_cnt_d = rep_cnt_q + REP_ONE;
                     if (last_rep && !last_phase) phase_d = phase_q + PHASE_ONE;
                  end else begin
                     count_d = count_q + CNT_ONE;
                  end
               end
            end
            S_DONE: begin
               count_d = '0;
               phase_d = '0;
            end
            default: begin
               count_d = '0;
               phase_d = '0;
            end
         endcase
      end

      busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q    <= '0;
         phase_q    <= '0;
         rep_cnt_q  <= '0;
         act_mod_q  <= '0;
         act_reps_q <= '0;
         wrap_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         count_q    <= count_d;
         phase_q    <= phase_d;
         rep_cnt_q  <= rep_cnt_d;
         act_mod_q  <= act_mod_d;
         act_reps_q <= act_reps_d;
         wrap_q     <= wrap_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign count_o = count_q;
   assign phase_o = phase_q;
   assign wrap_o  = wrap_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_mod_count_sequencer.sv
// Self-checking bench for mod_count_sequencer: table-driven vectors plus
// hand-written multi-cycle sequences, checked through an expected-value queue.
module tb_mod_count_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_idx = '0;
   logic [7:0] cfg_mod = '0;
   logic [7:0] cfg_reps = '0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] count;
   logic [1:0] phase;
   logic       wrap;
   logic       busy;
   logic       done;

   mod_count_sequencer #(.W(8), .NUM_PHASES(4), .PW(2)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .cfg_we_i   (cfg_we),
      .cfg_idx_i  (cfg_idx),
      .cfg_mod_i  (cfg_mod),
      .cfg_reps_i (cfg_reps),
      .start_i    (start),
      .pause_i    (pause),
      .abort_i    (abort),
      .count_o    (count),
      .phase_o    (phase),
      .wrap_o     (wrap),
      .busy_o     (busy),
      .done_o     (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] count;
      logic [1:0] phase;
      logic       wrap;
      logic       busy;
      logic       done;
   } obs_t;

   typedef struct {
      int         tag;
      logic       rst_n;
      logic       start;
      logic       pause;
      logic       abort;
      logic       we;
      logic [1:0] idx;
      logic [7:0] md;
      logic [7:0] rp;
      obs_t       exp;
   } vec_t;

   obs_t exp_q[$];
   vec_t vecs[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_step   = 0;

   function automatic vec_t r(input int tag, input logic st, input logic pa, input logic ab,
                              input logic [7:0] c, input logic [1:0] ph,
                              input logic w, input logic b, input logic d);
      vec_t v;
      v.tag = tag; v.rst_n = 1'b1; v.start = st; v.pause = pa; v.abort = ab;
      v.we = 1'b0; v.idx = '0; v.md = '0; v.rp = '0;
      v.exp = '{count: c, phase: ph, wrap: w, busy: b, done: d};
      return v;
   endfunction

   // Table write while idle: outputs must stay at their idle values.
   function automatic vec_t cw(input int tag, input logic [1:0] idx,
                               input logic [7:0] md, input logic [7:0] rp);
      vec_t v;
      v = r(tag, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      v.we = 1'b1; v.idx = idx; v.md = md; v.rp = rp;
      return v;
   endfunction

   // Reset cycle with start and a table write asserted; both must be ignored.
   function automatic vec_t rr(input int tag);
      vec_t v;
      v = cw(tag, 2'd0, 8'd3, 8'd2);
      v.rst_n = 1'b0; v.start = 1'b1;
      return v;
   endfunction

   task automatic step(input vec_t v);
      obs_t e;
      obs_t act;
      @(negedge clk);
      rst_n    = v.rst_n;
      start    = v.start;
      pause    = v.pause;
      abort    = v.abort;
      cfg_we   = v.we;
      cfg_idx  = v.idx;
      cfg_mod  = v.md;
      cfg_reps = v.rp;
      exp_q.push_back(v.exp);
      @(posedge clk);
      #1;
      e   = exp_q.pop_front();
      act = '{count: count, phase: phase, wrap: wrap, busy: busy, done: done};
      n_step++;
      n_checks++;
      if (act === e) begin
         n_pass++;
      end else begin
         $display("FAIL test%0d step %0d: got count=%0d phase=%0d wrap=%b busy=%b done=%b, expected count=%0d phase=%0d wrap=%b busy=%b done=%b",
                  v.tag, n_step, act.count, act.phase, act.wrap, act.busy, act.done,
                  e.count, e.phase, e.wrap, e.busy, e.done);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vec_t t;

      // Test 1: reset, then start with an empty table
      vecs.push_back(rr(1));
      vecs.push_back(rr(1));
      vecs.push_back(r(1, 1, 0, 0, 8'd0, 2'd0, 0, 1, 0));
      vecs.push_back(r(1, 0, 0, 0, 8'd0, 2'd1, 0, 1, 0));
      vecs.push_back(r(1, 0, 0, 0, 8'd0, 2'd2, 0, 1, 0));
      vecs.push_back(r(1, 0, 0, 0, 8'd0, 2'd3, 0, 1, 0));
      vecs.push_back(r(1, 0, 0, 0, 8'd0, 2'd3, 0, 0, 1));
      vecs.push_back(r(1, 0, 0, 0, 8'd0, 2'd0, 0, 0, 0));
      // Test 2: mod=3 reps=2 on entry 0 only
      vecs.push_back(cw(2, 2'd0, 8'd3, 8'd2));
      vecs.push_back(r(2, 1, 0, 0, 8'd0, 2'd0, 0, 1, 0));
      vecs.push_back(r(2, 0, 0, 0, 8'd0, 2'd0, 0, 1, 0));
      vecs.push_back(r(2, 0, 0, 0, 8'd1, 2'd0, 0, 1, 0));
      vecs.push_back(r(2, 0, 0, 0, 8'd2, 2'd0, 0, 1, 0));
      vecs.push_back(r(2, 0, 0, 0, 8'd0, 2'd0, 1, 1, 0));
      vecs.push_back(r(2, 0, 0, 0, 8'd1, 2'd0, 0, 1, 0));
      vecs.push_back(r(2, 0, 0, 0, 8'd2, 2'd0, 0, 1, 0));
      vecs.push_back(r(2, 0, 0, 0, 8'd0, 2'd1, 1, 1, 0));
      vecs.push_back(r(2, 0, 0, 0, 8'd0, 2'd2, 0, 1, 0));
      vecs.push_back(r(2, 0, 0, 0, 8'd0, 2'd3, 0, 1, 0));
      vecs.push_back(r(2, 0, 0, 0, 8'd0, 2'd3, 0, 0, 1));
      vecs.push_back(r(2, 0, 0, 0, 8'd0, 2'd0, 0, 0, 0));
      // Test 3: mod=1 reps=4 then mod=2 reps=1
      vecs.push_back(cw(3, 2'd0, 8'd1, 8'd4));
      vecs.push_back(cw(3, 2'd1, 8'd2, 8'd1));
      vecs.push_back(r(3, 1, 0, 0, 8'd0, 2'd0, 0, 1, 0));
      vecs.push_back(r(3, 0, 0, 0, 8'd0, 2'd0, 0, 1, 0));
      vecs.push_back(r(3, 0, 0, 0, 8'd0, 2'd0, 1, 1, 0));
      vecs.push_back(r(3, 0, 0, 0, 8'd0, 2'd0, 1, 1, 0));
      vecs.push_back(r(3, 0, 0, 0, 8'd0, 2'd0, 1, 1, 0));
      vecs.push_back(r(3, 0, 0, 0, 8'd0, 2'd1, 1, 1, 0));
      vecs.push_back(r(3, 0, 0, 0, 8'd0, 2'd1, 0, 1, 0));
      vecs.push_back(r(3, 0, 0, 0, 8'd1, 2'd1, 0, 1, 0));
      vecs.push_back(r(3, 0, 0, 0, 8'd0, 2'd2, 1, 1, 0));
      vecs.push_back(r(3, 0, 0, 0, 8'd0, 2'd3, 0, 1, 0));
      vecs.push_back(r(3, 0, 0, 0, 8'd0, 2'd3, 0, 0, 1));
      vecs.push_back(r(3, 0, 0, 0, 8'd0, 2'd0, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

      // Test 4: pause holds the counter; start ignored while running;
      // entries disabled by mod=0 and by reps=0
      step(cw(4, 2'd0, 8'd5, 8'd1));
      step(cw(4, 2'd1, 8'd0, 8'd1));
      step(cw(4, 2'd2, 8'd7, 8'd0));
      step(r(4, 1, 0, 0, 8'd0, 2'd0, 0, 1, 0));
      step(r(4, 0, 0, 0, 8'd0, 2'd0, 0, 1, 0));
      step(r(4, 0, 0, 0, 8'd1, 2'd0, 0, 1, 0));
      step(r(4, 0, 0, 0, 8'd2, 2'd0, 0, 1, 0));
      step(r(4, 0, 1, 0, 8'd2, 2'd0, 0, 1, 0));
      step(r(4, 1, 1, 0, 8'd2, 2'd0, 0, 1, 0));
      step(r(4, 0, 1, 0, 8'd2, 2'd0, 0, 1, 0));
      step(r(4, 0, 0, 0, 8'd3, 2'd0, 0, 1, 0));
      step(r(4, 0, 0, 0, 8'd4, 2'd0, 0, 1, 0));
      step(r(4, 0, 0, 0, 8'd0, 2'd1, 1, 1, 0));
      step(r(4, 0, 0, 0, 8'd0, 2'd2, 0, 1, 0));
      step(r(4, 0, 0, 0, 8'd0, 2'd3, 0, 1, 0));
      step(r(4, 0, 0, 0, 8'd0, 2'd3, 0, 0, 1));
      step(r(4, 0, 0, 0, 8'd0, 2'd0, 0, 0, 0));

      // Test 5: abort mid-run, abort+start in idle, then a full schedule
      step(cw(5, 2'd0, 8'd10, 8'd3));
      step(cw(5, 2'd1, 8'd0, 8'd0));
      step(cw(5, 2'd2, 8'd0, 8'd0));
      step(r(5, 1, 0, 0, 8'd0, 2'd0, 0, 1, 0));
      for (int n = 1; n <= 15; n++)
         step(r(5, 0, 0, 0, 8'((n - 1) % 10), 2'd0, (n > 1) && ((n - 1) % 10 == 0), 1'b1, 1'b0));
      step(r(5, 0, 0, 1, 8'd0, 2'd0, 0, 0, 0));
      step(r(5, 1, 0, 1, 8'd0, 2'd0, 0, 0, 0));
      step(r(5, 0, 0, 0, 8'd0, 2'd0, 0, 0, 0));
      step(r(5, 1, 0, 0, 8'd0, 2'd0, 0, 1, 0));
      for (int n = 1; n <= 30; n++)
         step(r(5, 0, 0, 0, 8'((n - 1) % 10), 2'd0, (n > 1) && ((n - 1) % 10 == 0), 1'b1, 1'b0));
      step(r(5, 0, 0, 0, 8'd0, 2'd1, 1, 1, 0));
      step(r(5, 0, 0, 0, 8'd0, 2'd2, 0, 1, 0));
      step(r(5, 0, 0, 0, 8'd0, 2'd3, 0, 1, 0));
      step(r(5, 0, 0, 0, 8'd0, 2'd3, 0, 0, 1));
      step(r(5, 0, 0, 0, 8'd0, 2'd0, 0, 0, 0));

      // Test 6: rewrite of the active entry applies only at its next LOAD
      step(cw(6, 2'd0, 8'd4, 8'd2));
      step(r(6, 1, 0, 0, 8'd0, 2'd0, 0, 1, 0));
      step(r(6, 0, 0, 0, 8'd0, 2'd0, 0, 1, 0));
      step(r(6, 0, 0, 0, 8'd1, 2'd0, 0, 1, 0));
      t = r(6, 0, 0, 0, 8'd2, 2'd0, 0, 1, 0);
      t.we = 1'b1; t.idx = 2'd0; t.md = 8'd2; t.rp = 8'd2;
      step(t);
      step(r(6, 0, 0, 0, 8'd3, 2'd0, 0, 1, 0));
      step(r(6, 0, 0, 0, 8'd0, 2'd0, 1, 1, 0));
      step(r(6, 0, 0, 0, 8'd1, 2'd0, 0, 1, 0));
      step(r(6, 0, 0, 0, 8'd2, 2'd0, 0, 1, 0));
      step(r(6, 0, 0, 0, 8'd3, 2'd0, 0, 1, 0));
      step(r(6, 0, 0, 0, 8'd0, 2'd1, 1, 1, 0));
      step(r(6, 0, 0, 0, 8'd0, 2'd2, 0, 1, 0));
      step(r(6, 0, 0, 0, 8'd0, 2'd3, 0, 1, 0));
      step(r(6, 0, 0, 0, 8'd0, 2'd3, 0, 0, 1));
      step(r(6, 0, 0, 0, 8'd0, 2'd0, 0, 0, 0));
      step(r(6, 1, 0, 0, 8'd0, 2'd0, 0, 1, 0));
      step(r(6, 0, 0, 0, 8'd0, 2'd0, 0, 1, 0));
      step(r(6, 0, 0, 0, 8'd1, 2'd0, 0, 1, 0));
      step(r(6, 0, 0, 0, 8'd0, 2'd0, 1, 1, 0));
      step(r(6, 0, 0, 0, 8'd1, 2'd0, 0, 1, 0));
      step(r(6, 0, 0, 0, 8'd0, 2'd1, 1, 1, 0));
      step(r(6, 0, 0, 0, 8'd0, 2'd2, 0, 1, 0));
      step(r(6, 0, 0, 0, 8'd0, 2'd3, 0, 1, 0));
      step(r(6, 0, 0, 0, 8'd0, 2'd3, 0, 0, 1));
      step(r(6, 0, 0, 0, 8'd0, 2'd0, 0, 0, 0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
